// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers for a 5-stage in-order core, with
// load-use hazard detection and retire/stall event counters.
module ex_mem_wb_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ex,
    input  logic [4:0]       ard_ex,
    input  logic             regwrite_ex,
    input  logic             memread_ex,
    input  logic             memtoreg_ex,
    input  logic [XLEN-1:0]  alu_result_ex,
    input  logic             flush_ex,
    input  logic             hold,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [4:0]       ars1_id,
    input  logic [4:0]       ars2_id,
    output logic [4:0]       ard_ex_mem,
    output logic             regwrite_ex_mem,
    output logic             memtoreg_ex_mem,
    output logic             valid_ex_mem,
    output logic [XLEN-1:0]  alu_result_ex_mem,
    output logic [4:0]       ard_mem_wb,
    output logic             regwrite_mem_wb,
    output logic             valid_mem_wb,
    output logic [XLEN-1:0]  wb_data_mem_wb,
    output logic             load_use_stall,
    output logic [31:0]      retire_count,
    output logic [CNT_W-1:0] stall_count
);

    logic ex_live;
    logic ard_ex_nz;

    assign ex_live   = valid_ex & ~flush_ex;
    assign ard_ex_nz = (ard_ex != 5'd0);

    // Pure function of the EX/ID fields; deliberately ignores hold and reset.
    assign load_use_stall = ex_live & memread_ex & ard_ex_nz &
                            ((ard_ex == ars1_id) | (ard_ex == ars2_id));

    always_ff @(posedge clk or posedge rst) begin : ex_mem_reg
        if (rst) begin
            ard_ex_mem        <= 5'd0;
            regwrite_ex_mem   <= 1'b0;
            memtoreg_ex_mem   <= 1'b0;
            valid_ex_mem      <= 1'b0;
            alu_result_ex_mem <= '0;
        end else if (!hold) begin
            if (ex_live) begin
                ard_ex_mem        <= ard_ex;
                regwrite_ex_mem   <= regwrite_ex & ard_ex_nz;
                memtoreg_ex_mem   <= memtoreg_ex;
                valid_ex_mem      <= 1'b1;
                alu_result_ex_mem <= alu_result_ex;
            end else begin
                ard_ex_mem        <= 5'd0;
                regwrite_ex_mem   <= 1'b0;
                memtoreg_ex_mem   <= 1'b0;
                valid_ex_mem      <= 1'b0;
                alu_result_ex_mem <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : mem_wb_reg
        if (rst) begin
            ard_mem_wb      <= 5'd0;
            regwrite_mem_wb <= 1'b0;
            valid_mem_wb    <= 1'b0;
            wb_data_mem_wb  <= '0;
        end else if (!hold) begin
            ard_mem_wb      <= ard_ex_mem;
            regwrite_mem_wb <= regwrite_ex_mem;
            valid_mem_wb    <= valid_ex_mem;
            wb_data_mem_wb  <= memtoreg_ex_mem ? mem_rdata : alu_result_ex_mem;
        end
    end

    // Retire count wraps naturally; stall count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin : event_counters
        if (rst) begin
            retire_count <= 32'd0;
            stall_count  <= '0;
        end else if (!hold) begin
            if (valid_ex_mem) begin
                retire_count <= retire_count + 32'd1;
            end
            if (load_use_stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: a two-slot pipeline model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ex_mem_wb_pipe;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             valid_ex;
    logic [4:0]       ard_ex;
    logic             regwrite_ex;
    logic             memread_ex;
    logic             memtoreg_ex;
    logic [XLEN-1:0]  alu_result_ex;
    logic             flush_ex;
    logic             hold;
    logic [XLEN-1:0]  mem_rdata;
    logic [4:0]       ars1_id;
    logic [4:0]       ars2_id;
    logic [4:0]       ard_ex_mem;
    logic             regwrite_ex_mem;
    logic             memtoreg_ex_mem;
    logic             valid_ex_mem;
    logic [XLEN-1:0]  alu_result_ex_mem;
    logic [4:0]       ard_mem_wb;
    logic             regwrite_mem_wb;
    logic             valid_mem_wb;
    logic [XLEN-1:0]  wb_data_mem_wb;
    logic             load_use_stall;
    logic [31:0]      retire_count;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    ex_mem_wb_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .ard_ex(ard_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
        .memtoreg_ex(memtoreg_ex), .alu_result_ex(alu_result_ex),
        .flush_ex(flush_ex), .hold(hold), .mem_rdata(mem_rdata),
        .ars1_id(ars1_id), .ars2_id(ars2_id),
        .ard_ex_mem(ard_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .memtoreg_ex_mem(memtoreg_ex_mem), .valid_ex_mem(valid_ex_mem),
        .alu_result_ex_mem(alu_result_ex_mem), .ard_mem_wb(ard_mem_wb),
        .regwrite_mem_wb(regwrite_mem_wb), .valid_mem_wb(valid_mem_wb),
        .wb_data_mem_wb(wb_data_mem_wb), .load_use_stall(load_use_stall),
        .retire_count(retire_count), .stall_count(stall_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    typedef struct packed {
        logic [4:0]  ard;
        logic        rw;
        logic        mt;
        logic        v;
        logic [31:0] data;
    } slot_t;

    slot_t       pipe [0:1];   // [0] = EX/MEM contents, [1] = MEM/WB contents
    logic [31:0] m_retire = 32'd0;
    logic [15:0] m_stall  = 16'd0;
    logic        p_stall = 1'b0, p_ret = 1'b0;
    logic [15:0] p_stall_val = 16'd0;
    logic [31:0] p_ret_val   = 32'd0;

    initial begin
        pipe[0] = '0;
        pipe[1] = '0;
    end

    function automatic logic stall_rule();
        return valid_ex && memread_ex && !flush_ex && (ard_ex != 5'd0) &&
               (ard_ex == ars1_id || ard_ex == ars2_id);
    endfunction

    always @(posedge clk or posedge rst) begin
        slot_t       entering;
        slot_t       leaving;
        logic [15:0] sbase;
        logic [31:0] rbase;
        if (rst) begin
            pipe[0]  <= '0;
            pipe[1]  <= '0;
            m_retire <= 32'd0;
            m_stall  <= 16'd0;
        end else if (!hold) begin
            entering = '0;
            if (valid_ex && !flush_ex) begin
                entering.ard  = ard_ex;
                entering.rw   = regwrite_ex && (ard_ex != 5'd0);
                entering.mt   = memtoreg_ex;
                entering.v    = 1'b1;
                entering.data = alu_result_ex;
            end
            leaving = pipe[0];
            if (leaving.mt) leaving.data = mem_rdata;
            pipe[0] <= entering;
            pipe[1] <= leaving;
            rbase = p_ret ? p_ret_val : m_retire;
            m_retire <= rbase + (pipe[0].v ? 32'd1 : 32'd0);
            sbase = p_stall ? p_stall_val : m_stall;
            m_stall <= (stall_rule() && sbase != 16'hFFFF) ? sbase + 16'd1 : sbase;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("ard_ex_mem",        {59'd0, ard_ex_mem},        {59'd0, pipe[0].ard});
        chk("regwrite_ex_mem",   {63'd0, regwrite_ex_mem},   {63'd0, pipe[0].rw});
        chk("memtoreg_ex_mem",   {63'd0, memtoreg_ex_mem},   {63'd0, pipe[0].mt});
        chk("valid_ex_mem",      {63'd0, valid_ex_mem},      {63'd0, pipe[0].v});
        chk("alu_result_ex_mem", {32'd0, alu_result_ex_mem}, {32'd0, pipe[0].data});
        chk("ard_mem_wb",        {59'd0, ard_mem_wb},        {59'd0, pipe[1].ard});
        chk("regwrite_mem_wb",   {63'd0, regwrite_mem_wb},   {63'd0, pipe[1].rw});
        chk("valid_mem_wb",      {63'd0, valid_mem_wb},      {63'd0, pipe[1].v});
        chk("wb_data_mem_wb",    {32'd0, wb_data_mem_wb},    {32'd0, pipe[1].data});
        chk("retire_count",      {32'd0, retire_count},      {32'd0, m_retire});
        chk("stall_count",       {48'd0, stall_count},       {48'd0, m_stall});
        chk("load_use_stall",    {63'd0, load_use_stall},    {63'd0, stall_rule()});
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic rw,
                             input logic mr, input logic mt, input logic [31:0] alu);
        valid_ex      = v;
        ard_ex        = rd;
        regwrite_ex   = rw;
        memread_ex    = mr;
        memtoreg_ex   = mt;
        alu_result_ex = alu;
    endtask

    task automatic clear_instr();
        set_instr(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; hold = 1'b0; flush_ex = 1'b0; mem_rdata = 32'd0;
        ars1_id = 5'd0; ars2_id = 5'd0;
        clear_instr();
        repeat (2) tick();
        chk("rst_ard_ex_mem", {59'd0, ard_ex_mem}, 64'd0);
        chk("rst_valid_mem_wb", {63'd0, valid_mem_wb}, 64'd0);
        chk("rst_retire", {32'd0, retire_count}, 64'd0);
        chk("rst_stall", {48'd0, stall_count}, 64'd0);
        rst = 1'b0;

        // pass-through ADD x5
        set_instr(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h10);
        tick();
        chk("add_ard_ex_mem", {59'd0, ard_ex_mem}, 64'd5);
        chk("add_regwrite_ex_mem", {63'd0, regwrite_ex_mem}, 64'd1);
        clear_instr();
        tick();
        chk("add_wb_data", {32'd0, wb_data_mem_wb}, 64'h10);
        chk("add_retire", {32'd0, retire_count}, 64'd1);

        // load x7 with dependent ID instruction
        set_instr(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 32'h100);
        ars1_id = 5'd7;
        #1 chk("load_stall_on", {63'd0, load_use_stall}, 64'd1);
        tick();
        chk("load_stall_count", {48'd0, stall_count}, 64'd1);
        clear_instr();
        ars1_id = 5'd0;
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("load_wb_data", {32'd0, wb_data_mem_wb}, 64'hDEADBEEF);
        chk("load_retire", {32'd0, retire_count}, 64'd2);
        set_instr(1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0);
        #1 chk("x0_no_stall", {63'd0, load_use_stall}, 64'd0);
        tick();
        clear_instr();
        tick();

        // flush and x0 write
        set_instr(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h55);
        flush_ex = 1'b1;
        tick();
        chk("flush_ard", {59'd0, ard_ex_mem}, 64'd0);
        chk("flush_valid", {63'd0, valid_ex_mem}, 64'd0);
        chk("flush_alu", {32'd0, alu_result_ex_mem}, 64'd0);
        flush_ex = 1'b0;
        clear_instr();
        tick();
        chk("flush_no_retire", {32'd0, retire_count}, 64'd3);
        set_instr(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h20);
        tick();
        chk("x0_regwrite", {63'd0, regwrite_ex_mem}, 64'd0);
        chk("x0_valid", {63'd0, valid_ex_mem}, 64'd1);
        clear_instr();
        tick();
        chk("x0_retire", {32'd0, retire_count}, 64'd4);

        // hold beats flush
        set_instr(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h99);
        tick();
        set_instr(1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 32'h77);
        ars1_id = 5'd10; flush_ex = 1'b1; hold = 1'b1;
        repeat (3) tick();
        chk("hold_ard_ex_mem", {59'd0, ard_ex_mem}, 64'd9);
        chk("hold_alu", {32'd0, alu_result_ex_mem}, 64'h99);
        chk("hold_ard_mem_wb", {59'd0, ard_mem_wb}, 64'd0);
        chk("hold_retire", {32'd0, retire_count}, 64'd4);
        hold = 1'b0; flush_ex = 1'b0; ars1_id = 5'd0;
        clear_instr();
        tick();
        chk("release_ard_mem_wb", {59'd0, ard_mem_wb}, 64'd9);
        chk("release_wb", {32'd0, wb_data_mem_wb}, 64'h99);
        chk("release_retire", {32'd0, retire_count}, 64'd5);

        // asynchronous reset between edges
        set_instr(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'hAB);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_ard_ex_mem", {59'd0, ard_ex_mem}, 64'd0);
        chk("arst_retire", {32'd0, retire_count}, 64'd0);
        chk("arst_stall", {48'd0, stall_count}, 64'd0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_capture", {59'd0, ard_ex_mem}, 64'd12);
        chk("post_rst_discard", {59'd0, ard_mem_wb}, 64'd0);
        clear_instr();
        tick();

        // stall counter saturation
        force dut.stall_count = 16'hFFFD;
        p_stall_val = 16'hFFFD; p_stall = 1'b1;
        #1 release dut.stall_count;
        set_instr(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0);
        ars2_id = 5'd4;
        tick();
        p_stall = 1'b0;
        chk("stall_near_sat", {48'd0, stall_count}, 64'hFFFE);
        repeat (3) tick();
        chk("stall_saturated", {48'd0, stall_count}, 64'hFFFF);
        clear_instr();
        ars2_id = 5'd0;
        tick();

        // retire counter wrap
        set_instr(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h5);
        tick();
        force dut.retire_count = 32'hFFFF_FFFF;
        p_ret_val = 32'hFFFF_FFFF; p_ret = 1'b1;
        #1 release dut.retire_count;
        clear_instr();
        tick();
        p_ret = 1'b0;
        chk("retire_wrap", {32'd0, retire_count}, 64'd0);

        // mixed traffic under the per-cycle model
        for (int i = 0; i < 40; i++) begin
            set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom);
            flush_ex  = ($urandom_range(0, 5) == 0);
            hold      = ($urandom_range(0, 4) == 0);
            mem_rdata = $urandom;
            ars1_id   = ($urandom_range(0, 2) == 0) ? ard_ex : 5'($urandom_range(0, 31));
            ars2_id   = 5'($urandom_range(0, 31));
            tick();
        end
        hold = 1'b0; flush_ex = 1'b0;
        clear_instr();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_pipe.md
EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the load-use stall counter width.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 VALID_EX  input  1  the EX stage holds a real instruction.
REQ-006 ARD_EX  input  5  destination register of the EX instruction.
REQ-007 REGWRITE_EX, MEMREAD_EX, MEMTOREG_EX  input  1 each  control bits of the EX instruction.
REQ-008 ALU_RESULT_EX  input  XLEN  ALU output, also the data-memory address.
REQ-009 FLUSH_EX  input  1  kill the EX instruction (branch taken or exception).
REQ-010 HOLD  input  1  global freeze (memory wait); both register stages keep their contents.
REQ-011 MEM_RDATA  input  XLEN  data-memory read data, valid combinationally during the MEM stage.
REQ-012 ARS1_ID, ARS2_ID  input  5 each  source registers of the instruction in ID.
REQ-013 ARD_EX_MEM, REGWRITE_EX_MEM, MEMTOREG_EX_MEM, VALID_EX_MEM  output  5/1/1/1  EX/MEM register fields.
REQ-014 ALU_RESULT_EX_MEM  output  XLEN  registered ALU result, used as the EX/MEM forwarding source.
REQ-015 ARD_MEM_WB, REGWRITE_MEM_WB, VALID_MEM_WB  output  5/1/1  MEM/WB register fields.
REQ-016 WB_DATA_MEM_WB  output  XLEN  registered write-back value, used as the MEM/WB forwarding source.
REQ-017 LOAD_USE_STALL  output  1  combinational load-use hazard request to ID/IF.
REQ-018 RETIRE_COUNT  output  32  number of instructions written into MEM/WB.
REQ-019 STALL_COUNT  output  CNT_W  number of cycles in which the load-use stall was asserted.

Function
REQ-020 On a rising edge with HOLD=0 and VALID_EX=1 and FLUSH_EX=0, the EX/MEM register SHALL capture ARD_EX, ALU_RESULT_EX, MEMTOREG_EX, VALID=1, and REGWRITE = REGWRITE_EX AND (ARD_EX!=0).
REQ-021 On a rising edge with HOLD=0 and either FLUSH_EX=1 or VALID_EX=0, the EX/MEM register SHALL load a bubble: all fields 0.
REQ-022 On a rising edge with HOLD=0, the MEM/WB register SHALL capture ARD, REGWRITE and VALID from EX/MEM.
REQ-023 In the same case, WB_DATA SHALL be MEM_RDATA when MEMTOREG_EX_MEM=1 and ALU_RESULT_EX_MEM otherwise.
REQ-024 When HOLD=1, both registers and both counters SHALL hold their values; HOLD SHALL take priority over FLUSH_EX, and a flush during HOLD SHALL be ignored.
REQ-025 Latency SHALL be one cycle from EX to EX/MEM and two cycles from EX to MEM/WB when HOLD=0.
REQ-026 A REGWRITE output SHALL never be 1 while its corresponding ARD is 0.
REQ-027 LOAD_USE_STALL SHALL be 1 exactly when VALID_EX=1, MEMREAD_EX=1, FLUSH_EX=0, ARD_EX!=0, and (ARD_EX==ARS1_ID or ARD_EX==ARS2_ID).
REQ-028 LOAD_USE_STALL SHALL be independent of HOLD.
REQ-029 RETIRE_COUNT SHALL increment by 1 on every rising edge with HOLD=0 where VALID_EX_MEM=1; it SHALL wrap from 2^32-1 to 0.
REQ-030 STALL_COUNT SHALL increment on every rising edge with HOLD=0 and LOAD_USE_STALL=1.
REQ-031 STALL_COUNT SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-032 The block SHALL contain no other state; the output fields SHALL be the register contents directly, with no combinational bypass.

Reset
REQ-033 While RST=1, all registered outputs and both counters SHALL be 0, asynchronously and regardless of CLK or HOLD.
REQ-034 A reset asserted mid-pipeline SHALL discard the in-flight instructions.
REQ-035 The first capture after reset SHALL occur on the first rising edge after RST deasserts.
REQ-036 LOAD_USE_STALL SHALL remain a pure function of its inputs during reset.

Verification
REQ-037 Pass-through: ADD to x5 with ALU=0x10 and HOLD=0 -> cycle+1 shows ARD_EX_MEM=5, REGWRITE_EX_MEM=1; cycle+2 shows WB_DATA_MEM_WB=0x10, RETIRE_COUNT=1.
REQ-038 Load: MEMTOREG=1, ALU=0x100, MEM_RDATA=0xDEADBEEF -> WB_DATA_MEM_WB=0xDEADBEEF; ARS1_ID=ARD_EX=7 with MEMREAD_EX=1 -> LOAD_USE_STALL=1 and STALL_COUNT +1; ARS1_ID=0 with ARD_EX=0 -> no stall.
REQ-039 Flush and x0 write: FLUSH_EX=1 -> EX/MEM all 0 and no retire; REGWRITE_EX=1 with ARD_EX=0 -> REGWRITE_EX_MEM=0.
REQ-040 HOLD: 3 cycles of HOLD=1 with FLUSH_EX=1 -> all outputs and counters unchanged; after release the pipeline advances normally.
REQ-041 Reset and counters: RST pulse between clock edges -> outputs go to 0 immediately; STALL_COUNT preset near saturation with stalls continuing -> holds at 0xFFFF for CNT_W=16; RETIRE_COUNT at 0xFFFFFFFF plus one retire -> 0.
